segre_icache_controller: RTL and testbench
==========================================

Name: segre_icache_controller

Overview:
- Sequencing controller for the instruction-cache data array.
- Accepts fetch requests from the IF stage, holds the tag/valid store, and performs the hit/miss check.
- On a miss it issues a lane-fill request to the MMU, steers the returned lane into the data array, then replays the lookup.
- Drives the data array's read/write strobes and address; the data array's registered data_o is the fetch data.

Parameters:
- ADDR_WIDTH, 32, fetch address width (equals WORD_SIZE).
- BYTE_SIZE, 4, byte-offset bits within a lane (ICACHE_BYTE_SIZE; 16-byte lane).
- INDEX_SIZE, 4, index bits (ICACHE_INDEX_SIZE; NUM_LANES = 2**INDEX_SIZE).
- TAG_SIZE, ADDR_WIDTH-INDEX_SIZE-BYTE_SIZE, stored tag width.

Ports:
- clk_i  in  1  clock.
- rsn_i  in  1  asynchronous active-low reset.
- fetch_req_i  in  1  fetch request valid.
- fetch_addr_i  in  ADDR_WIDTH  fetch address, word aligned.
- fetch_ready_o  out  1  request accepted this cycle.
- fetch_valid_o  out  1  data array data_o holds the requested word this cycle.
- invalidate_i  in  1  invalidate all lanes (fence.i).
- rd_data_o  out  1  data array read strobe.
- mmu_wr_data_o  out  1  data array lane-write strobe.
- cache_addr_o  out  ADDR_WIDTH  data array address (latched request address).
- mmu_req_o  out  1  lane-fill request to MMU.
- mmu_addr_o  out  ADDR_WIDTH  fill address, low BYTE_SIZE bits zero.
- mmu_ack_i  in  1  fill lane valid on the MMU data bus (1-cycle pulse).

Behaviour:
- Reset (async, rsn_i=0):
  - State is IDLE and all valid bits are cleared.
  - All outputs are 0 except fetch_ready_o=1.
  - Latched address is 0.
  - Reset asserted mid-miss abandons the fill; a late mmu_ack_i after reset release is ignored in IDLE.
- Address split: tag=addr[ADDR_WIDTH-1:INDEX_SIZE+BYTE_SIZE]; index=addr[INDEX_SIZE+BYTE_SIZE-1:BYTE_SIZE].
- IDLE:
  - fetch_ready_o=1.
  - fetch_req_i=1 latches fetch_addr_i and goes to LOOKUP.
  - invalidate_i=1 in IDLE clears all valid bits and takes priority: the request is not accepted that cycle (fetch_ready_o=0 while invalidate_i=1).
- LOOKUP (1 cycle):
  - Compares the stored tag and valid bit at the index.
  - Hit: rd_data_o=1 and go to RESP.
  - Miss: go to MISS.
- RESP (1 cycle):
  - fetch_valid_o=1, then go to IDLE.
  - Hit latency is 2 cycles from acceptance (edge N) to fetch_valid_o=1 (cycle N+2).
- MISS:
  - mmu_req_o=1 and mmu_addr_o=lane-aligned latched address; both held stable until mmu_ack_i.
  - mmu_ack_i=1 drives mmu_wr_data_o=1 in that same cycle, writes the tag and sets valid at the edge, then goes to LOOKUP.
  - Miss replay therefore always hits.
- cache_addr_o = latched address in every non-IDLE state.
- Only one outstanding request; fetch_ready_o=0 outside IDLE.
- invalidate_i outside IDLE: recorded in a pending flag and applied on the first IDLE cycle.
  - The in-flight fetch still completes and returns data.
  - The lane just filled is invalidated by the pending flush.
- Simultaneous invalidate_i and mmu_ack_i in MISS: the fill completes, the flush is pending.
- mmu_ack_i outside MISS is ignored.
- Tag/valid arrays are flops.

Optional Feature:
- Macro: SEGRE_ICACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
  - hit_cnt_o increments on each LOOKUP hit that is not a miss replay.
  - miss_cnt_o increments on each LOOKUP miss.
  - Both wrap modulo 2**32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss then hit:
  - Reset, then fetch 0x0000_1004 -> MISS with mmu_req_o=1 and mmu_addr_o=0x0000_1000.
  - mmu_ack_i after 5 cycles -> mmu_wr_data_o pulse, then fetch_valid_o 2 cycles later.
  - Re-fetch 0x0000_1008 -> fetch_valid_o at cycle N+2 with no mmu_req_o.
- Conflict eviction:
  - Fill 0x0000_1000, then fetch 0x0000_2000 (same index 0, different tag) -> miss.
  - Re-fetch 0x0000_1000 -> miss again.
- Invalidate in IDLE:
  - After filling index 0, pulse invalidate_i with fetch_req_i=1 -> fetch_ready_o=0 that cycle.
  - Next fetch of 0x0000_1000 -> miss.
- Invalidate during MISS:
  - Assert invalidate_i while waiting on mmu_ack_i -> fetch still returns fetch_valid_o.
  - Following fetch of the same address -> miss.
- Reset mid-miss:
  - Drop rsn_i while mmu_req_o=1 -> mmu_req_o=0 immediately, fetch_ready_o=1.
  - A stray mmu_ack_i after release -> no mmu_wr_data_o.
- Stats (SEGRE_ICACHE_STATS_EN):
  - Run 1 miss plus 3 hits -> miss_cnt_o=1 and hit_cnt_o=3.

Source files
------------

// File: rtl/segre_icache_controller.sv
// Instruction-cache sequencing controller: tag/valid store, hit/miss check, MMU lane fill and replay.
// Optional hit/miss counters are built when SEGRE_ICACHE_STATS_EN is defined.
module segre_icache_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4,
  parameter int INDEX_SIZE = 4,
  parameter int TAG_SIZE   = ADDR_WIDTH - INDEX_SIZE - BYTE_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  fetch_valid_o,
  input  logic                  invalidate_i,
  output logic                  rd_data_o,
  output logic                  mmu_wr_data_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic                  mmu_req_o,
  output logic [ADDR_WIDTH-1:0] mmu_addr_o,
  input  logic                  mmu_ack_i
`ifdef SEGRE_ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int NUM_LANES = 2 ** INDEX_SIZE;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, MISS} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    pending_q;
  logic [NUM_LANES-1:0]    valid_q;
  logic [TAG_SIZE-1:0]     tag_q [NUM_LANES];

  logic [INDEX_SIZE-1:0]   idx;
  logic [TAG_SIZE-1:0]     tag;
  logic                    hit;
  logic                    fill;
  logic                    flush;
  logic                    accept;

  assign idx    = addr_q[INDEX_SIZE+BYTE_SIZE-1:BYTE_SIZE];
  assign tag    = addr_q[ADDR_WIDTH-1:INDEX_SIZE+BYTE_SIZE];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign fill   = (state_q == MISS) && mmu_ack_i;
  // A flush requested while busy is deferred to the first IDLE cycle so the in-flight fetch completes.
  assign flush  = (state_q == IDLE) && (invalidate_i || pending_q);
  assign accept = (state_q == IDLE) && fetch_req_i && !invalidate_i;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      if (flush)
        valid_q <= '0;
      else if (fill)
        valid_q[idx] <= 1'b1;

      if (state_q == IDLE)
        pending_q <= 1'b0;
      else if (invalidate_i)
        pending_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= fetch_addr_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP:  state_q <= hit ? RESP : MISS;
        RESP:    state_q <= IDLE;
        MISS:    if (mmu_ack_i) state_q <= LOOKUP;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill)
      tag_q[idx] <= tag;
  end

  assign fetch_ready_o = (state_q == IDLE) && !invalidate_i;
  assign fetch_valid_o = (state_q == RESP);
  assign rd_data_o     = (state_q == LOOKUP) && hit;
  assign mmu_wr_data_o = fill;
  assign mmu_req_o     = (state_q == MISS);
  assign cache_addr_o  = (state_q != IDLE) ? addr_q : '0;
  assign mmu_addr_o    = (state_q == MISS) ? {addr_q[ADDR_WIDTH-1:BYTE_SIZE], {BYTE_SIZE{1'b0}}} : '0;

`ifdef SEGRE_ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        replay_q;

  // replay_q marks the LOOKUP that follows a fill so it is not counted as a hit.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      if (fill)
        replay_q <= 1'b1;
      else if (accept)
        replay_q <= 1'b0;

      if (state_q == LOOKUP) begin
        if (!hit)
          miss_cnt_q <= miss_cnt_q + 32'd1;
        else if (!replay_q)
          hit_cnt_q <= hit_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_segre_icache_controller.sv
// Bench for segre_icache_controller: directed scenarios plus randomized fetch traffic against a lane-table model.
module tb_segre_icache_controller;

  logic        clk_i;
  logic        rsn_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        fetch_valid_o;
  logic        invalidate_i;
  logic        rd_data_o;
  logic        mmu_wr_data_o;
  logic [31:0] cache_addr_o;
  logic        mmu_req_o;
  logic [31:0] mmu_addr_o;
  logic        mmu_ack_i;
`ifdef SEGRE_ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  segre_icache_controller dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_valid_o(fetch_valid_o),
    .invalidate_i (invalidate_i),
    .rd_data_o    (rd_data_o),
    .mmu_wr_data_o(mmu_wr_data_o),
    .cache_addr_o (cache_addr_o),
    .mmu_req_o    (mmu_req_o),
    .mmu_addr_o   (mmu_addr_o),
    .mmu_ack_i    (mmu_ack_i)
`ifdef SEGRE_ICACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors;
  int miscompares;

  // Reference model: which line (address >> 4) each of the 16 lanes currently holds.
  bit          m_valid [16];
  logic [27:0] m_line  [16];
  int          m_hits;
  int          m_misses;

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tg, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_stats();
`ifdef SEGRE_ICACHE_STATS_EN
    check("hit_cnt", hit_cnt_o, 32'(m_hits));
    check("miss_cnt", miss_cnt_o, 32'(m_misses));
`endif
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
    fetch_req_i = 1'b0; invalidate_i = 1'b0; mmu_ack_i = 1'b0;
    @(negedge clk_i);
    check("idle_ready", 32'(fetch_ready_o), 32'd1);
    check("idle_valid", 32'(fetch_valid_o), 32'd0);
    check("idle_mmu_req", 32'(mmu_req_o), 32'd0);
  endtask

  // One complete fetch; the expected hit/miss comes from the lane table.
  task automatic do_fetch(input logic [31:0] a, input int ack_dly, input bit inv_miss);
    int  lane;
    bit  exp_hit;
    lane    = int'(a[7:4]);
    exp_hit = m_valid[lane] && (m_line[lane] == a[31:4]);
    @(posedge clk_i); #1;
    fetch_req_i = 1'b1; fetch_addr_i = a; invalidate_i = 1'b0; mmu_ack_i = 1'b0;
    @(negedge clk_i);
    check("accept_ready", 32'(fetch_ready_o), 32'd1);
    @(posedge clk_i); #1;
    fetch_req_i = 1'b0; fetch_addr_i = $urandom;
    @(negedge clk_i);
    check("lookup_rd", 32'(rd_data_o), 32'(exp_hit));
    check("lookup_addr", cache_addr_o, a);
    check("lookup_busy", 32'(fetch_ready_o), 32'd0);
    check("lookup_mmu_req", 32'(mmu_req_o), 32'd0);
    if (!exp_hit) begin
      m_misses++;
      for (int i = 0; i <= ack_dly; i++) begin
        @(posedge clk_i); #1;
        mmu_ack_i    = (i == ack_dly);
        invalidate_i = inv_miss && (i == 0);
        @(negedge clk_i);
        check("miss_req", 32'(mmu_req_o), 32'd1);
        check("miss_addr", mmu_addr_o, {a[31:4], 4'h0});
        check("miss_wr", 32'(mmu_wr_data_o), 32'(i == ack_dly));
        check("miss_valid", 32'(fetch_valid_o), 32'd0);
      end
      m_valid[lane] = 1'b1;
      m_line[lane]  = a[31:4];
      @(posedge clk_i); #1;
      mmu_ack_i = 1'b0; invalidate_i = 1'b0;
      @(negedge clk_i);
      check("replay_rd", 32'(rd_data_o), 32'd1);
      check("replay_mmu_req", 32'(mmu_req_o), 32'd0);
    end else begin
      m_hits++;
    end
    @(posedge clk_i); #1;
    mmu_ack_i = 1'b0; invalidate_i = 1'b0;
    @(negedge clk_i);
    check("resp_valid", 32'(fetch_valid_o), 32'd1);
    check("resp_mmu_req", 32'(mmu_req_o), 32'd0);
    if (inv_miss && !exp_hit) model_flush();
  endtask

  task automatic idle_invalidate(input bit with_req, input logic [31:0] a);
    @(posedge clk_i); #1;
    invalidate_i = 1'b1; fetch_req_i = with_req; fetch_addr_i = a; mmu_ack_i = 1'b0;
    @(negedge clk_i);
    check("inv_ready", 32'(fetch_ready_o), 32'd0);
    model_flush();
    @(posedge clk_i); #1;
    invalidate_i = 1'b0; fetch_req_i = 1'b0;
    @(negedge clk_i);
    check("inv_not_accepted", 32'(rd_data_o | mmu_req_o | fetch_valid_o), 32'd0);
    check("inv_after_ready", 32'(fetch_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    vectors = 0; miscompares = 0;
    m_hits = 0; m_misses = 0;
    model_flush();
    rsn_i = 1'b0; fetch_req_i = 1'b0; fetch_addr_i = '0; invalidate_i = 1'b0; mmu_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(fetch_ready_o), 32'd1);
    check("rst_outs", 32'(fetch_valid_o | rd_data_o | mmu_wr_data_o | mmu_req_o), 32'd0);
    check("rst_cache_addr", cache_addr_o, 32'd0);
    check("rst_mmu_addr", mmu_addr_o, 32'd0);
    check_stats();
    @(posedge clk_i); #1 rsn_i = 1'b1;

    // Cold miss, then hit in the same lane; then conflict eviction.
    do_fetch(32'h0000_1004, 5, 1'b0);
    do_fetch(32'h0000_1008, 0, 1'b0);
    do_fetch(32'h0000_100C, 0, 1'b0);
    do_fetch(32'h0000_1000, 0, 1'b0);
    check_stats();
    do_fetch(32'h0000_2000, 2, 1'b0);
    do_fetch(32'h0000_1000, 1, 1'b0);
    idle_cycle();

    // Invalidate in IDLE with a concurrent request, then miss.
    idle_invalidate(1'b1, 32'h0000_1000);
    do_fetch(32'h0000_1000, 0, 1'b0);

    // Invalidate during MISS (also simultaneous with the ack), then miss again.
    do_fetch(32'h0000_5010, 3, 1'b1);
    do_fetch(32'h0000_5010, 0, 1'b0);
    do_fetch(32'h0000_6020, 0, 1'b1);
    do_fetch(32'h0000_6020, 1, 1'b0);
    check_stats();

    // Reset mid-miss, then a stray ack in IDLE.
    a = 32'h0000_3040;
    idle_invalidate(1'b0, 32'h0);
    @(posedge clk_i); #1 fetch_req_i = 1'b1; fetch_addr_i = a;
    @(posedge clk_i); #1 fetch_req_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("pre_rst_req", 32'(mmu_req_o), 32'd1);
    #1 rsn_i = 1'b0;
    #1;
    check("rst_mid_req", 32'(mmu_req_o), 32'd0);
    check("rst_mid_ready", 32'(fetch_ready_o), 32'd1);
    check("rst_mid_addr", cache_addr_o, 32'd0);
    model_flush();
    m_hits = 0; m_misses = 0;
    @(posedge clk_i); #1 rsn_i = 1'b1;
    @(posedge clk_i); #1 mmu_ack_i = 1'b1;
    @(negedge clk_i);
    check("stray_ack_wr", 32'(mmu_wr_data_o), 32'd0);
    check("stray_ack_ready", 32'(fetch_ready_o), 32'd1);
    @(posedge clk_i); #1 mmu_ack_i = 1'b0;
    @(negedge clk_i);
    check("stray_ack_idle", 32'(rd_data_o | mmu_req_o | fetch_valid_o), 32'd0);
    check_stats();
    do_fetch(a, 0, 1'b0);

    // Randomized traffic over a few tags and lanes.
    for (int n = 0; n < 60; n++) begin
      a = {22'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) idle_invalidate(1'($urandom_range(0, 1)), a);
      do_fetch(a, int'($urandom_range(0, 4)), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
